// File: rtl/exec_stage.sv
// exec_stage: RV64 execute stage. Integer ALU, address generation and branch
// compare with one-cycle latency, plus an optional iterative M-extension
// multiply/divide unit that stalls upstream while it runs.
// Build option: define EXEC_MULDIV_EN to include the multiply/divide FSM and
// datapath. Without it, md ops complete in one cycle with alu_res = 0.
//
// Muldiv FSM states:
//   state  | meaning
//   S_IDLE | no md op in flight; accepting a md op raises stall_o
//   S_BUSY | one radix-2 iteration per cycle, stall_o high
//   S_DONE | result ready; registered to outputs on leaving, stall_o low
module exec_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [63:0] PC_i,
  input  logic [63:0] rs1_i,
  input  logic [63:0] rs2_i,
  input  logic [63:0] imm_i,
  input  logic [4:0]  rd_i,
  input  logic [3:0]  alu_op_i,
  input  logic        md_en_i,
  input  logic [2:0]  md_op_i,
  input  logic        word_i,
  input  logic        is_mem_i,
  input  logic        LOAD_i,
  input  logic [2:0]  mem_para_i,
  input  logic        branch_flag_i,
  input  logic        write_back_i,
  output logic        EN,
  output logic [63:0] address,
  output logic [63:0] value,
  output logic        LOAD,
  output logic [2:0]  mem_para,
  output logic [63:0] alu_res,
  output logic [4:0]  rd_o,
  output logic        write_back,
  output logic        branch_flag_o,
  output logic [63:0] branch_offset,
  output logic [63:0] PC_o,
  output logic        stall_o
);

  typedef struct packed {
    logic        en;
    logic [63:0] address;
    logic [63:0] value;
    logic        load;
    logic [2:0]  mem_para;
    logic [63:0] alu_res;
    logic [4:0]  rd;
    logic        write_back;
    logic        branch_flag;
    logic [63:0] branch_offset;
    logic [63:0] pc;
  } out_t;

  out_t        out_d, out_q;
  logic [63:0] opb, a_w, b_w, srl_src, alu_r, alu_y;
  logic [5:0]  shamt;
  logic [63:0] md_res;
  logic        md_stall;

  // Single-cycle ALU; *W ops work on sign-extended low words
  always_comb begin
    opb = branch_flag_i ? rs2_i : imm_i;
    if (word_i) begin
      a_w     = {{32{rs1_i[31]}}, rs1_i[31:0]};
      b_w     = {{32{opb[31]}}, opb[31:0]};
      shamt   = {1'b0, opb[4:0]};
      srl_src = {32'd0, rs1_i[31:0]};
    end else begin
      a_w     = rs1_i;
      b_w     = opb;
      shamt   = opb[5:0];
      srl_src = rs1_i;
    end
    case (alu_op_i)
      4'd0:          alu_r = a_w + b_w;
      4'd1:          alu_r = a_w - b_w;
      4'd2:          alu_r = a_w << shamt;
      4'd3, 4'd12:   alu_r = {63'd0, $signed(a_w) < $signed(b_w)};
      4'd4, 4'd14:   alu_r = {63'd0, a_w < b_w};
      4'd5:          alu_r = a_w ^ b_w;
      4'd6:          alu_r = srl_src >> shamt;
      4'd7:          alu_r = $signed(a_w) >>> shamt;
      4'd8:          alu_r = a_w | b_w;
      4'd9:          alu_r = a_w & b_w;
      4'd10:         alu_r = {63'd0, a_w == b_w};
      4'd11:         alu_r = {63'd0, a_w != b_w};
      4'd13:         alu_r = {63'd0, $signed(a_w) >= $signed(b_w)};
      default:       alu_r = {63'd0, a_w >= b_w};
    endcase
    alu_y = word_i ? {{32{alu_r[31]}}, alu_r[31:0]} : alu_r;
  end

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [64:0]  hi_q, hi_d;
  logic [63:0]  lo_q, lo_d, dv_q, dv_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [2:0]   op_q, op_d;
  logic         wd_q, wd_d, negq_q, negq_d, negr_q, negr_d;
  logic         sa, sb, sign_a, sign_b;
  logic [63:0]  a_x, b_x, ua, ub;
  logic [128:0] step_init, step_cur;
  logic [127:0] prod, prod_s;
  logic [63:0]  quo, rem, md_raw;

  // One radix-2 iteration: shift-add multiply or restoring divide on {hi,lo}
  function automatic logic [128:0] md_step(input logic [64:0] hi, input logic [63:0] lo,
                                           input logic [63:0] dv, input logic is_div);
    logic [64:0] t;
    if (is_div) begin
      t = {hi[63:0], lo[63]};
      if (t >= {1'b0, dv}) return {t - {1'b0, dv}, lo[62:0], 1'b1};
      else                 return {t, lo[62:0], 1'b0};
    end else begin
      t = hi + (lo[0] ? {1'b0, dv} : 65'd0);
      return {1'b0, t, lo[63:1]};
    end
  endfunction

  // Operand magnitudes and sign fixups; the first iteration runs on the accept cycle
  always_comb begin
    sa        = (md_op_i == 3'd1) || (md_op_i == 3'd2) || (md_op_i == 3'd4) || (md_op_i == 3'd6);
    sb        = (md_op_i == 3'd1) || (md_op_i == 3'd4) || (md_op_i == 3'd6);
    a_x       = word_i ? {{32{sa & rs1_i[31]}}, rs1_i[31:0]} : rs1_i;
    b_x       = word_i ? {{32{sb & rs2_i[31]}}, rs2_i[31:0]} : rs2_i;
    sign_a    = sa & a_x[63];
    sign_b    = sb & b_x[63];
    ua        = sign_a ? -a_x : a_x;
    ub        = sign_b ? -b_x : b_x;
    step_init = md_step(65'd0, (md_op_i[2] && word_i) ? {ua[31:0], 32'd0} : ua, ub, md_op_i[2]);
    step_cur  = md_step(hi_q, lo_q, dv_q, op_q[2]);
  end

  // Result selection from the finished iteration registers
  always_comb begin
    prod   = wd_q ? {64'd0, hi_q[31:0], lo_q[63:32]} : {hi_q[63:0], lo_q};
    prod_s = negq_q ? -prod : prod;
    quo    = wd_q ? {32'd0, lo_q[31:0]} : lo_q;
    rem    = wd_q ? {32'd0, hi_q[31:0]} : hi_q[63:0];
    case (op_q)
      3'd0:       md_raw = prod_s[63:0];
      3'd1, 3'd2,
      3'd3:       md_raw = prod_s[127:64];
      3'd4, 3'd5: md_raw = negq_q ? -quo : quo;
      default:    md_raw = negr_q ? -rem : rem;
    endcase
    md_res = wd_q ? {{32{md_raw[31]}}, md_raw[31:0]} : md_raw;
  end

  // Muldiv next-state, iteration update and stall request
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dv_d     = dv_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    wd_d     = wd_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    md_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && md_en_i && !flush_i) begin
          md_stall = 1'b1;
          hi_d     = step_init[128:64];
          lo_d     = step_init[63:0];
          dv_d     = ub;
          cnt_d    = word_i ? 6'd31 : 6'd63;
          op_d     = md_op_i;
          wd_d     = word_i;
          // divide by zero keeps the all-ones quotient unsigned
          negq_d   = sign_a ^ sign_b && !(md_op_i[2] && b_x == 64'd0);
          negr_d   = sign_a;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          md_stall = 1'b1;
          hi_d     = step_cur[128:64];
          lo_d     = step_cur[63:0];
          cnt_d    = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Muldiv state and iteration registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      wd_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      wd_q    <= wd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end
`else
  logic unused_md;
  assign unused_md = ^md_op_i;
  assign md_res    = 64'd0;
  assign md_stall  = 1'b0;
`endif

  // Next output register contents; anything not issuing is a bubble
  always_comb begin
    out_d = '0;
    if (valid_i && !flush_i && !md_stall) begin
      out_d.en = is_mem_i;
      if (is_mem_i) begin
        out_d.address  = rs1_i + imm_i;
        out_d.value    = rs2_i;
        out_d.load     = LOAD_i;
        out_d.mem_para = mem_para_i;
      end
      out_d.alu_res       = md_en_i ? md_res : alu_y;
      out_d.rd            = rd_i;
      out_d.write_back    = write_back_i;
      out_d.branch_flag   = branch_flag_i;
      out_d.branch_offset = imm_i;
      out_d.pc            = PC_i;
    end
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (!RST_N) out_q <= '0;
    else        out_q <= out_d;
  end

  assign EN            = out_q.en;
  assign address       = out_q.address;
  assign value         = out_q.value;
  assign LOAD          = out_q.load;
  assign mem_para      = out_q.mem_para;
  assign alu_res       = out_q.alu_res;
  assign rd_o          = out_q.rd;
  assign write_back    = out_q.write_back;
  assign branch_flag_o = out_q.branch_flag;
  assign branch_offset = out_q.branch_offset;
  assign PC_o          = out_q.pc;
  assign stall_o       = md_stall & RST_N;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: ALU vector table, memory/bubble/reset
// sequences, and muldiv sequences when EXEC_MULDIV_EN is defined.
module tb_exec_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        valid_i, flush_i, md_en_i, word_i, is_mem_i, LOAD_i, branch_flag_i, write_back_i;
  logic [63:0] PC_i, rs1_i, rs2_i, imm_i;
  logic [4:0]  rd_i;
  logic [3:0]  alu_op_i;
  logic [2:0]  md_op_i, mem_para_i;
  logic        EN, LOAD, write_back, branch_flag_o, stall_o;
  logic [63:0] address, value, alu_res, branch_offset, PC_o;
  logic [2:0]  mem_para;
  logic [4:0]  rd_o;

  int n_cmp = 0;
  int n_bad = 0;

  exec_stage dut (
    .CLK(CLK), .RST_N(RST_N), .valid_i(valid_i), .flush_i(flush_i), .PC_i(PC_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .rd_i(rd_i), .alu_op_i(alu_op_i),
    .md_en_i(md_en_i), .md_op_i(md_op_i), .word_i(word_i), .is_mem_i(is_mem_i),
    .LOAD_i(LOAD_i), .mem_para_i(mem_para_i), .branch_flag_i(branch_flag_i),
    .write_back_i(write_back_i), .EN(EN), .address(address), .value(value), .LOAD(LOAD),
    .mem_para(mem_para), .alu_res(alu_res), .rd_o(rd_o), .write_back(write_back),
    .branch_flag_o(branch_flag_o), .branch_offset(branch_offset), .PC_o(PC_o),
    .stall_o(stall_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        bf;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [63:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(input string n, input logic [3:0] op, input logic bf, input logic w,
                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                               input logic [63:0] exp);
    vec_t t;
    t.name = n; t.op = op; t.bf = bf; t.w = w; t.a = a; t.b = b; t.imm = imm; t.exp = exp;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; flush_i = 1'b0; md_en_i = 1'b0; word_i = 1'b0; is_mem_i = 1'b0;
    LOAD_i = 1'b0; branch_flag_i = 1'b0; write_back_i = 1'b0; PC_i = '0; rs1_i = '0;
    rs2_i = '0; imm_i = '0; rd_i = '0; alu_op_i = '0; md_op_i = '0; mem_para_i = '0;
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] imm, input logic [4:0] rd);
    idle_inputs();
    valid_i = 1'b1; alu_op_i = op; rs1_i = a; imm_i = imm; rd_i = rd; write_back_i = 1'b1;
    PC_i = 64'h0000_0000_0040_0000;
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, ".EN"}, 64'(EN), 64'd0);
    chk({nm, ".write_back"}, 64'(write_back), 64'd0);
    chk({nm, ".rd_o"}, 64'(rd_o), 64'd0);
    chk({nm, ".branch_flag_o"}, 64'(branch_flag_o), 64'd0);
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic run_md(input string nm, input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int exp_cyc, input logic [63:0] exp);
    int cyc;
    idle_inputs();
    valid_i = 1'b1; md_en_i = 1'b1; md_op_i = op; word_i = w; rs1_i = a; rs2_i = b;
    imm_i = 64'h55; rd_i = 5'd9; write_back_i = 1'b1;
    cyc = 0;
    while (stall_o === 1'b1 && cyc < 200) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk({nm, ".stall_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, ".done_bubble_wb"}, 64'(write_back), 64'd0);
    @(posedge CLK); #1;
    chk({nm, ".res"}, alu_res, exp);
    chk({nm, ".rd_o"}, 64'(rd_o), 64'd9);
    idle_inputs();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vq.push_back(mkv("add_neg",  4'd0,  1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE));
    vq.push_back(mkv("sub",      4'd1,  1'b0, 1'b0, 64'd10, 64'd0, 64'd3, 64'd7));
    vq.push_back(mkv("sll_mask", 4'd2,  1'b0, 1'b0, 64'd1, 64'd0, 64'h43, 64'd8));
    vq.push_back(mkv("sllw",     4'd2,  1'b0, 1'b1, 64'd1, 64'd0, 64'h3F, 64'hFFFF_FFFF_8000_0000));
    vq.push_back(mkv("slt",      4'd3,  1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 64'd1));
    vq.push_back(mkv("sltu",     4'd4,  1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 64'd0));
    vq.push_back(mkv("xor",      4'd5,  1'b0, 1'b0, 64'hF0F0, 64'd0, 64'hFF00, 64'h0FF0));
    vq.push_back(mkv("srl",      4'd6,  1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 64'd1));
    vq.push_back(mkv("sra",      4'd7,  1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 64'hF800_0000_0000_0000));
    vq.push_back(mkv("sraw",     4'd7,  1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'd4, 64'hFFFF_FFFF_F800_0000));
    vq.push_back(mkv("srlw",     4'd6,  1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'd4, 64'h0000_0000_0800_0000));
    vq.push_back(mkv("or",       4'd8,  1'b0, 1'b0, 64'hF0, 64'd0, 64'h0F, 64'hFF));
    vq.push_back(mkv("and",      4'd9,  1'b0, 1'b0, 64'hFF, 64'd0, 64'h3C, 64'h3C));
    vq.push_back(mkv("beq",      4'd10, 1'b1, 1'b0, 64'd7, 64'd7, 64'h20, 64'd1));
    vq.push_back(mkv("bne",      4'd11, 1'b1, 1'b0, 64'd7, 64'd7, 64'h20, 64'd0));
    vq.push_back(mkv("blt",      4'd12, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'd1));
    vq.push_back(mkv("bge",      4'd13, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'd0));
    vq.push_back(mkv("bltu",     4'd14, 1'b1, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8, 64'd1));
    vq.push_back(mkv("bgeu",     4'd15, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h8, 64'd1));
    vq.push_back(mkv("addw_ovf", 4'd0,  1'b0, 1'b1, 64'h7FFF_FFFF, 64'd0, 64'd1, 64'hFFFF_FFFF_8000_0000));
    vq.push_back(mkv("opb_rs2",  4'd0,  1'b1, 1'b0, 64'd1, 64'd2, 64'd100, 64'd3));

    // reset: stall must stay low even with an md op presented
    idle_inputs();
    RST_N = 1'b0; valid_i = 1'b1; md_en_i = 1'b1; md_op_i = 3'd4; rd_i = 5'd3; write_back_i = 1'b1;
    #1;
    chk("reset.stall_o", 64'(stall_o), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.stall_o_after_edges", 64'(stall_o), 64'd0);
    chk("reset.alu_res", alu_res, 64'd0);
    chk("reset.PC_o", PC_o, 64'd0);
    chk_bubble("reset");
    idle_inputs();
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // ALU table
    foreach (vq[i]) begin
      idle_inputs();
      valid_i = 1'b1; alu_op_i = vq[i].op; branch_flag_i = vq[i].bf; word_i = vq[i].w;
      rs1_i = vq[i].a; rs2_i = vq[i].b; imm_i = vq[i].imm; rd_i = 5'(i + 1); write_back_i = 1'b1;
      PC_i = 64'h0000_0000_8000_0000 + 64'(i * 4);
      @(posedge CLK); #1;
      chk({vq[i].name, ".alu_res"}, alu_res, vq[i].exp);
      chk({vq[i].name, ".branch_flag_o"}, 64'(branch_flag_o), 64'(vq[i].bf));
      chk({vq[i].name, ".EN"}, 64'(EN), 64'd0);
      chk({vq[i].name, ".rd_o"}, 64'(rd_o), 64'(i + 1));
      chk({vq[i].name, ".write_back"}, 64'(write_back), 64'd1);
      chk({vq[i].name, ".PC_o"}, PC_o, 64'h0000_0000_8000_0000 + 64'(i * 4));
      chk({vq[i].name, ".branch_offset"}, branch_offset, vq[i].imm);
    end

    // load and store address generation
    drive_alu(4'd0, 64'h1000, 64'h10, 5'd6);
    is_mem_i = 1'b1; LOAD_i = 1'b1; mem_para_i = 3'd3; rs2_i = 64'hDEAD;
    @(posedge CLK); #1;
    chk("load.EN", 64'(EN), 64'd1);
    chk("load.address", address, 64'h1010);
    chk("load.LOAD", 64'(LOAD), 64'd1);
    chk("load.mem_para", 64'(mem_para), 64'd3);
    drive_alu(4'd0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0);
    is_mem_i = 1'b1; LOAD_i = 1'b0; mem_para_i = 3'd2; rs2_i = 64'h1234_5678_9ABC_DEF0; write_back_i = 1'b0;
    @(posedge CLK); #1;
    chk("store.EN", 64'(EN), 64'd1);
    chk("store.address", address, 64'h1FF8);
    chk("store.value", value, 64'h1234_5678_9ABC_DEF0);
    chk("store.LOAD", 64'(LOAD), 64'd0);
    chk("store.mem_para", 64'(mem_para), 64'd2);

    // valid low and flush both give bubbles
    drive_alu(4'd0, 64'd1, 64'd1, 5'd5);
    is_mem_i = 1'b1; branch_flag_i = 1'b1; valid_i = 1'b0;
    @(posedge CLK); #1;
    chk_bubble("invalid");
    valid_i = 1'b1; flush_i = 1'b1;
    @(posedge CLK); #1;
    chk_bubble("flush");

    // reset arriving after a live result clears it
    drive_alu(4'd0, 64'd1, 64'd1, 5'd7);
    @(posedge CLK); #1;
    chk("prereset.alu_res", alu_res, 64'd2);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    chk("midreset.alu_res", alu_res, 64'd0);
    chk("midreset.PC_o", PC_o, 64'd0);
    chk_bubble("midreset");
    RST_N = 1'b1;
    idle_inputs();
    @(posedge CLK); #1;

`ifdef EXEC_MULDIV_EN
    run_md("div_by_zero",  3'd4, 1'b0, 64'd100, 64'd0, 64, 64'hFFFF_FFFF_FFFF_FFFF);
    run_md("rem_by_zero",  3'd6, 1'b0, 64'd100, 64'd0, 64, 64'd100);
    run_md("divw_ovf",     3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32, 64'hFFFF_FFFF_8000_0000);
    run_md("div_ovf",      3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64, 64'h8000_0000_0000_0000);
    run_md("rem_ovf",      3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64, 64'd0);
    run_md("mul_neg",      3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64, 64'hFFFF_FFFF_FFFF_FFF1);
    run_md("mulhu_max",    3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64, 64'hFFFF_FFFF_FFFF_FFFE);
    run_md("mulh_m1m1",    3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64, 64'd0);
    run_md("mulh_minx2",   3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFF);
    run_md("div_neg",      3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md("rem_neg",      3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFF);
    run_md("divu",         3'd5, 1'b0, 64'd100, 64'd7, 64, 64'd14);
    run_md("remuw",        3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 32, 64'd5);
    run_md("mulw",         3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 32, 64'hFFFF_FFFF_FFFF_FFFE);

    // flush during iteration 10 of a MUL
    idle_inputs();
    valid_i = 1'b1; md_en_i = 1'b1; md_op_i = 3'd0; rs1_i = 64'd3; rs2_i = 64'd5; rd_i = 5'd4; write_back_i = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("mulflush.stall_busy", 64'(stall_o), 64'd1);
    flush_i = 1'b1;
    @(posedge CLK); #1;
    idle_inputs();
    #1;
    chk("mulflush.stall_o", 64'(stall_o), 64'd0);
    chk_bubble("mulflush");
    drive_alu(4'd0, 64'd2, 64'd3, 5'd11);
    #1;
    chk("postflush.stall_o", 64'(stall_o), 64'd0);
    @(posedge CLK); #1;
    chk("postflush.alu_res", alu_res, 64'd5);
    chk("postflush.rd_o", 64'(rd_o), 64'd11);
    run_md("after_flush_mulw", 3'd0, 1'b1, 64'h10000, 64'h10000, 32, 64'd0);

    // reset in the middle of a divide
    idle_inputs();
    valid_i = 1'b1; md_en_i = 1'b1; md_op_i = 3'd4; rs1_i = 64'd50; rs2_i = 64'd5; rd_i = 5'd2; write_back_i = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mdreset.stall_o", 64'(stall_o), 64'd0);
    @(posedge CLK); #1;
    chk_bubble("mdreset");
    RST_N = 1'b1;
    run_md("after_reset_div", 3'd4, 1'b0, 64'd50, 64'd5, 64, 64'd10);
`else
    // md ops without the muldiv unit: one cycle, zero result, no stall
    idle_inputs();
    valid_i = 1'b1; md_en_i = 1'b1; md_op_i = 3'd4; rs1_i = 64'd100; rs2_i = 64'd0; imm_i = 64'd1;
    rd_i = 5'd3; write_back_i = 1'b1;
    #1;
    chk("md_off.stall_o", 64'(stall_o), 64'd0);
    @(posedge CLK); #1;
    chk("md_off.alu_res", alu_res, 64'd0);
    chk("md_off.write_back", 64'(write_back), 64'd1);
    chk("md_off.rd_o", 64'(rd_o), 64'd3);
    chk("md_off.stall_after", 64'(stall_o), 64'd0);
    idle_inputs();
`endif

    @(posedge CLK); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
